// File: rtl/noise_gen_if.sv
// Register/strobe bundle between the APU register file and the noise voice.
// The master modport drives the controls and the slave modport (the voice) returns the sample.
interface noise_gen_if #(
  parameter int unsigned VOL_WIDTH = 4
) ();
  logic                 quarter_frame;
  logic                 half_frame;
  logic                 channel_enable;
  logic [VOL_WIDTH-1:0] volume;
  logic                 constant_volume;
  logic                 length_halt;
  logic [3:0]           timer_select;
  logic                 mode_short;
  logic [4:0]           length_select;
  logic                 reg_event;
  logic [VOL_WIDTH-1:0] noise_out;
  logic                 length_active;

  modport master (
    output quarter_frame, half_frame, channel_enable, volume, constant_volume,
           length_halt, timer_select, mode_short, length_select, reg_event,
    input  noise_out, length_active
  );

  modport slave (
    input  quarter_frame, half_frame, channel_enable, volume, constant_volume,
           length_halt, timer_select, mode_short, length_select, reg_event,
    output noise_out, length_active
  );
endinterface

// File: rtl/noise_gen.sv
// APU noise voice: period timer stepping a Fibonacci LFSR, length counter, registered output.
// Define NOISE_GEN_ENVELOPE_EN to build the envelope/decay unit; otherwise output is constant volume.
module noise_gen #(
  parameter int unsigned LFSR_WIDTH  = 15,
  parameter int unsigned TAP_SHORT   = 6,
  parameter int unsigned TIMER_WIDTH = 12,
  parameter int unsigned VOL_WIDTH   = 4
) (
  input logic        clk,
  input logic        rst_n,
  noise_gen_if.slave bus
);

  logic [TIMER_WIDTH-1:0] w_preset;
  logic [7:0]             w_len_load;
  logic                   w_fb;
  logic [VOL_WIDTH-1:0]   w_level;

  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   r_timer_event;
  logic [LFSR_WIDTH-1:0]  r_lfsr;
  logic [7:0]             r_length;
  logic                   r_length_active;
  logic [VOL_WIDTH-1:0]   r_noise_out;

  always_comb begin
    w_preset = '0;
    case (bus.timer_select)
      4'd0:  w_preset = TIMER_WIDTH'(4);
      4'd1:  w_preset = TIMER_WIDTH'(8);
      4'd2:  w_preset = TIMER_WIDTH'(16);
      4'd3:  w_preset = TIMER_WIDTH'(32);
      4'd4:  w_preset = TIMER_WIDTH'(64);
      4'd5:  w_preset = TIMER_WIDTH'(96);
      4'd6:  w_preset = TIMER_WIDTH'(128);
      4'd7:  w_preset = TIMER_WIDTH'(160);
      4'd8:  w_preset = TIMER_WIDTH'(202);
      4'd9:  w_preset = TIMER_WIDTH'(254);
      4'd10: w_preset = TIMER_WIDTH'(380);
      4'd11: w_preset = TIMER_WIDTH'(508);
      4'd12: w_preset = TIMER_WIDTH'(762);
      4'd13: w_preset = TIMER_WIDTH'(1016);
      4'd14: w_preset = TIMER_WIDTH'(2034);
      default: w_preset = TIMER_WIDTH'(4068);
    endcase
  end

  always_comb begin
    w_len_load = 8'd0;
    case (bus.length_select)
      5'd0:  w_len_load = 8'd10;   5'd1:  w_len_load = 8'd254;
      5'd2:  w_len_load = 8'd20;   5'd3:  w_len_load = 8'd2;
      5'd4:  w_len_load = 8'd40;   5'd5:  w_len_load = 8'd4;
      5'd6:  w_len_load = 8'd80;   5'd7:  w_len_load = 8'd6;
      5'd8:  w_len_load = 8'd160;  5'd9:  w_len_load = 8'd8;
      5'd10: w_len_load = 8'd60;   5'd11: w_len_load = 8'd10;
      5'd12: w_len_load = 8'd14;   5'd13: w_len_load = 8'd12;
      5'd14: w_len_load = 8'd26;   5'd15: w_len_load = 8'd14;
      5'd16: w_len_load = 8'd12;   5'd17: w_len_load = 8'd16;
      5'd18: w_len_load = 8'd24;   5'd19: w_len_load = 8'd18;
      5'd20: w_len_load = 8'd48;   5'd21: w_len_load = 8'd20;
      5'd22: w_len_load = 8'd96;   5'd23: w_len_load = 8'd22;
      5'd24: w_len_load = 8'd192;  5'd25: w_len_load = 8'd24;
      5'd26: w_len_load = 8'd72;   5'd27: w_len_load = 8'd26;
      5'd28: w_len_load = 8'd16;   5'd29: w_len_load = 8'd28;
      5'd30: w_len_load = 8'd32;   default: w_len_load = 8'd30;
    endcase
  end

  // Timer reloads only on zero, so a new timer_select lands at the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer       <= '0;
      r_timer_event <= 1'b0;
    end else begin
      r_timer_event <= (r_timer == '0);
      r_timer       <= (r_timer == '0) ? w_preset : r_timer - TIMER_WIDTH'(1);
    end
  end

  assign w_fb = r_lfsr[0] ^ (bus.mode_short ? r_lfsr[TAP_SHORT] : r_lfsr[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_WIDTH'(1);
    end else if (r_timer_event) begin
      r_lfsr <= {w_fb, r_lfsr[LFSR_WIDTH-1:1]};
    end else if (r_lfsr == '0) begin
      r_lfsr <= LFSR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_length        <= '0;
      r_length_active <= 1'b0;
    end else begin
      r_length_active <= (r_length != '0);
      if (!bus.channel_enable) begin
        r_length <= '0;
      end else if (bus.reg_event) begin
        r_length <= w_len_load;
      end else if (bus.half_frame && (r_length != '0) && !bus.length_halt) begin
        r_length <= r_length - 8'd1;
      end
    end
  end

`ifdef NOISE_GEN_ENVELOPE_EN
  logic                 r_start;
  logic [VOL_WIDTH-1:0] r_divider;
  logic [VOL_WIDTH-1:0] r_decay;

  // A reg_event coinciding with quarter_frame re-arms start for the following quarter frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start   <= 1'b0;
      r_divider <= '0;
      r_decay   <= '0;
    end else begin
      if (bus.quarter_frame) begin
        if (r_start) begin
          r_decay   <= '1;
          r_divider <= bus.volume;
        end else if (r_divider != '0) begin
          r_divider <= r_divider - VOL_WIDTH'(1);
        end else begin
          r_divider <= bus.volume;
          if (r_decay != '0)         r_decay <= r_decay - VOL_WIDTH'(1);
          else if (bus.length_halt)  r_decay <= '1;
        end
      end
      if (bus.reg_event)          r_start <= 1'b1;
      else if (bus.quarter_frame) r_start <= 1'b0;
    end
  end

  assign w_level = bus.constant_volume ? bus.volume : r_decay;
`else
  logic w_unused;
  assign w_unused = bus.quarter_frame ^ bus.constant_volume;
  assign w_level  = bus.volume;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_noise_out <= '0;
    end else begin
      r_noise_out <= ((r_length == '0) || r_lfsr[0]) ? '0 : w_level;
    end
  end

  assign bus.noise_out     = r_noise_out;
  assign bus.length_active = r_length_active;

endmodule

// File: tb/tb_noise_gen.sv
// Bench for noise_gen: directed scenarios plus randomized traffic against a behavioural model.
// Envelope checks are built only when NOISE_GEN_ENVELOPE_EN is defined, matching the DUT build.
module tb_noise_gen;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  noise_gen_if #(.VOL_WIDTH(4)) ifc ();

  noise_gen #(
    .LFSR_WIDTH  (15),
    .TAP_SHORT   (6),
    .TIMER_WIDTH (12),
    .VOL_WIDTH   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int PRESET [16] = '{4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016, 2034, 4068};
  int LEN_TAB [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Model state: clocks until the next step, pending step, LFSR value, length, envelope, outputs.
  int m_timer, m_tev, m_lfsr, m_len, m_act, m_start, m_div, m_decay, m_out;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_tev = 0; m_lfsr = 1; m_len = 0; m_act = 0;
    m_start = 0; m_div = 0; m_decay = 0; m_out = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_clk();
    int n_timer, n_tev, n_lfsr, n_len, n_start, n_div, n_decay, n_out, fb, tap, lvl;
    n_tev   = (m_timer == 0);
    n_timer = (m_timer == 0) ? PRESET[ifc.timer_select] : m_timer - 1;
    tap     = ifc.mode_short ? 6 : 1;
    if (m_tev != 0) begin
      fb     = (m_lfsr ^ (m_lfsr >> tap)) & 1;
      n_lfsr = (m_lfsr >> 1) | (fb << 14);
    end else begin
      n_lfsr = (m_lfsr == 0) ? 1 : m_lfsr;
    end
    if (!ifc.channel_enable)                                     n_len = 0;
    else if (ifc.reg_event)                                      n_len = LEN_TAB[ifc.length_select];
    else if (ifc.half_frame && m_len > 0 && !ifc.length_halt)    n_len = m_len - 1;
    else                                                         n_len = m_len;
    n_start = m_start; n_div = m_div; n_decay = m_decay;
`ifdef NOISE_GEN_ENVELOPE_EN
    if (ifc.quarter_frame) begin
      if (m_start != 0) begin
        n_decay = 15; n_div = int'(ifc.volume);
      end else if (m_div > 0) begin
        n_div = m_div - 1;
      end else begin
        n_div = int'(ifc.volume);
        if (m_decay > 0)          n_decay = m_decay - 1;
        else if (ifc.length_halt) n_decay = 15;
      end
    end
    if (ifc.reg_event)          n_start = 1;
    else if (ifc.quarter_frame) n_start = 0;
    lvl = ifc.constant_volume ? int'(ifc.volume) : m_decay;
`else
    lvl = int'(ifc.volume);
`endif
    n_out = (m_len == 0 || (m_lfsr & 1) != 0) ? 0 : lvl;
    m_act = (m_len != 0);
    m_timer = n_timer; m_tev = n_tev; m_lfsr = n_lfsr; m_len = n_len;
    m_start = n_start; m_div = n_div; m_decay = n_decay; m_out = n_out;
  endtask

  task automatic tick();
    model_clk();
    @(posedge clk);
    @(negedge clk);
    check_eq("noise_out", int'(ifc.noise_out), m_out);
    check_eq("length_active", int'(ifc.length_active), m_act);
    check_eq("lfsr", int'(dut.r_lfsr), m_lfsr);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int steps, prev, first_steps, ret1, ret2;
    n_checks = 0; n_fail = 0;
    ifc.quarter_frame = 0; ifc.half_frame = 0; ifc.channel_enable = 0; ifc.volume = '0;
    ifc.constant_volume = 0; ifc.length_halt = 0; ifc.timer_select = '0; ifc.mode_short = 0;
    ifc.length_select = '0; ifc.reg_event = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_noise_out", int'(ifc.noise_out), 0);
    check_eq("reset_length_active", int'(ifc.length_active), 0);
    check_eq("reset_lfsr", int'(dut.r_lfsr), 1);
    rst_n = 1'b1;

    // First step lands 1 clk after the timer zero, then every 5 clks.
    tick(); tick();
    check_eq("lfsr_step1", int'(dut.r_lfsr), 'h4000);
    repeat (5) tick();
    check_eq("lfsr_step2", int'(dut.r_lfsr), 'h2000);
    repeat (5) tick();

    // Short mode from seed 1: 93-step cycle, 465 clks between returns to 1.
    ifc.mode_short = 1;
    reset_pulse();
    steps = 0; first_steps = 0; ret1 = -1; ret2 = -1;
    prev = int'(dut.r_lfsr);
    for (int t = 1; t <= 1200 && ret2 < 0; t++) begin
      tick();
      if (int'(dut.r_lfsr) != prev) begin
        steps++;
        if (dut.r_lfsr == 15'd1) begin
          if (ret1 < 0) begin ret1 = t; first_steps = steps; end
          else ret2 = t;
        end
      end
      prev = int'(dut.r_lfsr);
    end
    check_eq("short_period_steps", first_steps, 93);
    check_eq("short_period_clks", ret2 - ret1, 465);
    ifc.mode_short = 0;

    // Length counter 2 -> 1 -> 0, then silence.
    ifc.channel_enable = 1; ifc.length_select = 5'd3; ifc.volume = 4'd7;
    ifc.constant_volume = 1;
    ifc.reg_event = 1; tick(); ifc.reg_event = 0;
    check_eq("len_load", int'(dut.r_length), 2);
    ifc.half_frame = 1; tick(); ifc.half_frame = 0;
    check_eq("len_dec1", int'(dut.r_length), 1);
    tick();
    check_eq("len_active_hi", int'(ifc.length_active), 1);
    ifc.half_frame = 1; tick(); ifc.half_frame = 0;
    check_eq("len_dec0", int'(dut.r_length), 0);
    ifc.half_frame = 1; tick(); ifc.half_frame = 0;
    check_eq("len_no_wrap", int'(dut.r_length), 0);
    check_eq("len_active_lo", int'(ifc.length_active), 0);
    repeat (10) begin
      tick();
      check_eq("silent_after_len0", int'(ifc.noise_out), 0);
    end
    ifc.channel_enable = 0; ifc.reg_event = 1; tick(); ifc.reg_event = 0;
    check_eq("len_disabled", int'(dut.r_length), 0);

    // Reload beats a coincident half_frame.
    ifc.channel_enable = 1; ifc.length_select = 5'd7;
    ifc.reg_event = 1; tick(); ifc.reg_event = 0;
    ifc.half_frame = 1; tick(); ifc.half_frame = 0;
    check_eq("len_five", int'(dut.r_length), 5);
    ifc.length_select = 5'd1; ifc.reg_event = 1; ifc.half_frame = 1; tick();
    ifc.reg_event = 0; ifc.half_frame = 0;
    check_eq("len_reload_wins", int'(dut.r_length), 254);
    tick();

`ifdef NOISE_GEN_ENVELOPE_EN
    ifc.volume = 4'd2; ifc.constant_volume = 0; ifc.length_halt = 0;
    ifc.reg_event = 1; ifc.length_select = 5'd1; tick(); ifc.reg_event = 0;
    for (int q = 1; q <= 49; q++) begin
      if (q == 8) ifc.length_halt = 1;
      ifc.quarter_frame = 1; tick(); ifc.quarter_frame = 0; tick();
      if (q == 1)  check_eq("env_qf1", int'(dut.r_decay), 15);
      if (q == 4)  check_eq("env_qf4", int'(dut.r_decay), 14);
      if (q == 7)  check_eq("env_qf7", int'(dut.r_decay), 13);
      if (q == 46) check_eq("env_zero", int'(dut.r_decay), 0);
      if (q == 49) check_eq("env_loop", int'(dut.r_decay), 15);
    end
    ifc.length_halt = 0;
`else
    ifc.volume = 4'd9; ifc.constant_volume = 0;
    ifc.length_select = 5'd1; ifc.reg_event = 1; tick(); ifc.reg_event = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      check_eq("const_vol_level", int'(ifc.noise_out), (m_out == 0) ? 0 : 9);
    end
`endif

    // Asynchronous reset mid-count clears outputs without waiting for a clock.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_noise_out", int'(ifc.noise_out), 0);
    check_eq("async_rst_length_active", int'(ifc.length_active), 0);
    check_eq("async_rst_lfsr", int'(dut.r_lfsr), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    ifc.channel_enable = 1;
    for (int i = 0; i < 3000; i++) begin
      ifc.quarter_frame  = ($urandom_range(0, 7) == 0);
      ifc.half_frame     = ($urandom_range(0, 15) == 0);
      ifc.reg_event      = ($urandom_range(0, 40) == 0);
      ifc.channel_enable = ($urandom_range(0, 80) != 0);
      ifc.length_select  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 150) == 0) ifc.timer_select = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 300) == 0) ifc.mode_short = ~ifc.mode_short;
      if ($urandom_range(0, 100) == 0) ifc.volume = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 200) == 0) ifc.constant_volume = ~ifc.constant_volume;
      if ($urandom_range(0, 200) == 0) ifc.length_halt = ~ifc.length_halt;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_gen.md
Name: noise_gen

Overview:
- Parametrised noise voice for the APU.
- Contains:
  - a period timer driving a Galois-free (Fibonacci) LFSR with selectable long/short tap,
  - a length counter,
  - an envelope/decay unit.
- Clocked by the APU master clock; quarter-frame and half-frame strobes come from the frame sequencer.
- `noise_out` feeds the mixer; `length_active` feeds the status register.

Parameters:
- LFSR_WIDTH, 15, shift-register width; feedback enters bit LFSR_WIDTH-1.
- TAP_SHORT, 6, second tap in short mode (bit 0 XOR bit TAP_SHORT); must be 1..LFSR_WIDTH-1.
- TIMER_WIDTH, 12, timer counter width; must be ≥12.
- VOL_WIDTH, 4, volume/envelope width; decay restart value is all-ones (15 at default).

Ports:
- clk  in  1  APU master clock; timer ticks once per clk.
- rst_n  in  1  asynchronous, active-low reset.
- quarter_frame  in  1  one-clk strobe; clocks the envelope.
- half_frame  in  1  one-clk strobe; clocks the length counter.
- channel_enable  in  1  status-register enable bit; low forces length to 0.
- volume  in  VOL_WIDTH  envelope period / constant volume.
- constant_volume  in  1  1 = output `volume`; 0 = output decay level.
- length_halt  in  1  halts length counter; also envelope loop flag.
- timer_select  in  4  index into period table.
- mode_short  in  1  1 = short tap (bits 0, TAP_SHORT); 0 = bits 0, 1.
- length_select  in  5  index into length table.
- reg_event  in  1  one-clk strobe on length-register write.
- noise_out  out  VOL_WIDTH  registered sample to mixer.
- length_active  out  1  length counter non-zero.

Behaviour:
- Reset (async, rst_n=0) values:
  - timer=0, timer_event=0, lfsr=1;
  - length=0, envelope start=0, divider=0, decay=0;
  - noise_out=0, length_active=0.
- Timer:
  - At 0: reloads preset; else decrements.
  - timer_event is registered from timer==0, so the LFSR steps 1 clk after the zero.
  - Step period is preset+1 clks.
  - Preset table, index 0..15: 4, 8, 16, 32, 64, 96, 128, 160, 202, 254, 380, 508, 762, 1016, 2034, 4068. Zero-extended to TIMER_WIDTH.
  - A timer_select change takes effect at the next reload; there is no mid-count restart.
- LFSR:
  - On timer_event: lfsr <= {fb, lfsr[LFSR_WIDTH-1:1]}.
  - fb = lfsr[0]^lfsr[1] (mode_short=0), or lfsr[0]^lfsr[TAP_SHORT] (mode_short=1); taps are pre-shift bits.
  - If lfsr==0 with no timer_event, force lfsr to 1 (lock-up recovery).
  - A mode switch takes effect on the next step; there is no reseed.
- Length counter (8 bit):
  - Priority order:
    1. channel_enable=0 → 0.
    2. reg_event → table[length_select].
    3. half_frame && length!=0 && !length_halt → decrement.
  - reg_event coincident with half_frame: reload wins, no decrement that clk.
  - Never wraps below 0.
  - Table, index 0..31: 10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14, 12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30.
  - length_active = registered (length!=0).
- Envelope:
  - reg_event sets the start flag.
  - On quarter_frame with start set: clear start, decay=max, divider=volume.
  - On quarter_frame without start:
    - divider!=0 → divider-1.
    - divider==0 → divider=volume, and:
      - decay!=0 → decay-1;
      - decay==0 && length_halt → decay=max;
      - else hold 0.
  - reg_event and quarter_frame in the same clk: start is set and processed on the next quarter_frame, not this one.
- Output, registered with 1 clk latency:
  - noise_out=0 if length==0 or lfsr[0]==1;
  - else volume when constant_volume=1;
  - else decay.

Optional Feature:
- Macro: NOISE_GEN_ENVELOPE_EN.
- Defined: envelope unit built as described above.
- Undefined:
  - No envelope unit is built.
  - quarter_frame and constant_volume are ignored.
  - noise_out uses `volume` directly (constant-volume only).
  - Length, timer and LFSR behaviour are unchanged.

Test Plan:
- Reset, timer_select=0, mode_short=0, hold 12 clks → first LFSR step 1 clk after timer hits 0; steps every 5 clks; lfsr 0x0001→0x4000→0x2000.
- mode_short=1, timer_select=0, from lfsr=1 → lfsr returns to 0x0001 after exactly 93 steps (465 clks); mode 0 → 32767 steps.
- channel_enable=1, length_select=3, length_halt=0, reg_event, then 2 half_frame → length 2→1→0; length_active drops; noise_out=0 thereafter. With channel_enable=0, reg_event leaves length 0.
- Envelope: volume=2, constant_volume=0, reg_event, then quarter_frames:
  - QF1 → decay=15;
  - QF4 → 14;
  - QF7 → 13.
  - With length_halt=1, after decay reaches 0, the next divider expiry → decay=15.
- reg_event coincident with half_frame while length=5, length_select=1 → length=254, no decrement; rst_n pulsed low mid-count → all outputs 0 immediately, lfsr=1.
- Build without NOISE_GEN_ENVELOPE_EN: volume=9, constant_volume=0 → noise_out ∈ {0, 9} following !lfsr[0] while length!=0.
